// File: rtl/rv_pkg.sv
// Shared RV32I memory-stage constants, access state encoding and store lane helpers.
package rv_pkg;

  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  typedef enum logic [1:0] {IDLE, REQ, WAIT} mem_state_t;

  function automatic logic [3:0] store_be(input logic [2:0] f3, input logic [1:0] a);
    logic [3:0] be;
    case (f3)
      F3_SB:   be = 4'b0001 << a;
      F3_SH:   be = 4'b0011 << {a[1], 1'b0};
      default: be = 4'b1111;
    endcase
    return be;
  endfunction

  function automatic logic [31:0] store_lanes(input logic [2:0] f3, input logic [31:0] d);
    logic [31:0] w;
    case (f3)
      F3_SB:   w = {4{d[7:0]}};
      F3_SH:   w = {2{d[15:0]}};
      default: w = d;
    endcase
    return w;
  endfunction

endpackage

// File: rtl/mem_load_align.sv
// Picks the addressed byte/halfword out of a load word and sign- or zero-extends it.
module mem_load_align
  import rv_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  addr_lo,
  input  logic [2:0]  funct3,
  output logic [31:0] data
);

  logic [31:0] shifted;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    shifted  = rdata >> {addr_lo, 3'b000};
    byte_sel = shifted[7:0];
    half_sel = addr_lo[1] ? rdata[31:16] : rdata[15:0];
    case (funct3)
      F3_LB:   data = {{24{byte_sel[7]}}, byte_sel};
      F3_LBU:  data = {24'b0, byte_sel};
      F3_LH:   data = {{16{half_sel[15]}}, half_sel};
      F3_LHU:  data = {16'b0, half_sel};
      default: data = rdata;
    endcase
  end

endmodule

// File: rtl/mem_stage.sv
// RV32I memory stage: single-outstanding load/store bus master with one-cycle pass-through.
// Optional misaligned-access trap is compiled in with MEM_STAGE_MISALIGN_TRAP_EN.
module mem_stage
  import rv_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int XLEN   = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              valid_in,
  input  logic [6:0]        opcode_in,
  input  logic [2:0]        funct3_in,
  input  logic [XLEN-1:0]   result_in,
  input  logic [XLEN-1:0]   store_data_in,
  input  logic [4:0]        rd_in,
  output logic              stall_out,
  output logic              dmem_req,
  output logic              dmem_we,
  output logic [ADDR_W-1:0] dmem_addr,
  output logic [3:0]        dmem_be,
  output logic [XLEN-1:0]   dmem_wdata,
  input  logic              dmem_gnt,
  input  logic              dmem_rvalid,
  input  logic [XLEN-1:0]   dmem_rdata,
  output logic              valid_out,
  output logic              rd_write_out,
  output logic [4:0]        rd_out,
  output logic [XLEN-1:0]   wb_data_out,
  output logic              misalign_out
);

  mem_state_t state, state_next;

  logic            is_load, is_store, is_branch;
  logic            mem_op, trap, bus_access, accept_mem, pass_accept, pass_rd_write;
  logic [2:0]      funct3_q;
  logic [1:0]      addr_lo_q;
  logic [4:0]      rd_mem_q;
  logic            valid_q, rd_write_q, mis_q;
  logic [4:0]      rd_q;
  logic [XLEN-1:0] wb_q;
  logic [XLEN-1:0] load_word;

  always_comb begin
    is_load   = (opcode_in == OPC_LOAD);
    is_store  = (opcode_in == OPC_STORE);
    is_branch = (opcode_in == OPC_BRANCH);
    mem_op    = (is_load && (funct3_in inside {F3_LB, F3_LH, F3_LW, F3_LBU, F3_LHU})) ||
                (is_store && (funct3_in inside {F3_SB, F3_SH, F3_SW}));
  end

`ifdef MEM_STAGE_MISALIGN_TRAP_EN
  // Halfword ops share funct3[1:0]=01 and word ops 10 across loads and stores.
  assign trap = mem_op && (((funct3_in[1:0] == 2'b01) && result_in[0]) ||
                           ((funct3_in[1:0] == 2'b10) && (result_in[1:0] != 2'b00)));
`else
  assign trap = 1'b0;
`endif

  assign bus_access    = mem_op && !trap;
  assign accept_mem    = (state == IDLE) && valid_in && bus_access;
  assign pass_accept   = (state == IDLE) && valid_in && !bus_access;
  assign pass_rd_write = !is_load && !is_store && !is_branch && (rd_in != 5'd0);

  mem_load_align u_align (
    .rdata   (dmem_rdata),
    .addr_lo (addr_lo_q),
    .funct3  (funct3_q),
    .data    (load_word)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      dmem_req   <= 1'b0;
      dmem_we    <= 1'b0;
      dmem_addr  <= '0;
      dmem_be    <= 4'b0;
      dmem_wdata <= '0;
      funct3_q   <= 3'b0;
      addr_lo_q  <= 2'b0;
      rd_mem_q   <= 5'b0;
      valid_q    <= 1'b0;
      rd_write_q <= 1'b0;
      rd_q       <= 5'b0;
      wb_q       <= '0;
      mis_q      <= 1'b0;
    end else begin
      state <= state_next;
      if (accept_mem) begin
        dmem_req   <= 1'b1;
        dmem_we    <= is_store;
        dmem_addr  <= {result_in[ADDR_W-1:2], 2'b00};
        dmem_be    <= store_be(funct3_in, result_in[1:0]);
        dmem_wdata <= store_lanes(funct3_in, store_data_in);
        funct3_q   <= funct3_in;
        addr_lo_q  <= result_in[1:0];
        rd_mem_q   <= rd_in;
      end else if ((state == REQ) && dmem_gnt) begin
        dmem_req <= 1'b0;
      end
      // Pass-through slot only lives for the cycle after it was accepted.
      valid_q    <= pass_accept;
      rd_write_q <= pass_accept && !trap && pass_rd_write;
      rd_q       <= pass_accept ? rd_in : 5'b0;
      wb_q       <= pass_accept ? result_in : '0;
      mis_q      <= pass_accept && trap;
    end
  end

  // Memory completions drive the writeback slot directly in the grant/rvalid cycle.
  always_comb begin
    state_next   = state;
    stall_out    = 1'b0;
    valid_out    = valid_q;
    rd_write_out = rd_write_q;
    rd_out       = rd_q;
    wb_data_out  = wb_q;
    misalign_out = mis_q;
    case (state)
      IDLE: begin
        if (accept_mem) begin
          state_next = REQ;
          stall_out  = 1'b1;
        end
      end
      REQ: begin
        stall_out = !(dmem_gnt && dmem_we);
        if (dmem_gnt) begin
          if (dmem_we) begin
            state_next   = IDLE;
            valid_out    = 1'b1;
            rd_write_out = 1'b0;
            rd_out       = rd_mem_q;
            wb_data_out  = '0;
          end else begin
            state_next = WAIT;
          end
        end
      end
      WAIT: begin
        stall_out = !dmem_rvalid;
        if (dmem_rvalid) begin
          state_next   = IDLE;
          valid_out    = 1'b1;
          rd_write_out = (rd_mem_q != 5'd0);
          rd_out       = rd_mem_q;
          wb_data_out  = load_word;
        end
      end
      default: state_next = IDLE;
    endcase
  end

endmodule

// File: tb/tb_mem_stage.sv
// Directed self-checking bench for mem_stage: pass-through, stores, loads, reset and misalign.
module tb_mem_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        valid_in;
  logic [6:0]  opcode_in;
  logic [2:0]  funct3_in;
  logic [31:0] result_in;
  logic [31:0] store_data_in;
  logic [4:0]  rd_in;
  logic        stall_out;
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [3:0]  dmem_be;
  logic [31:0] dmem_wdata;
  logic        dmem_gnt;
  logic        dmem_rvalid;
  logic [31:0] dmem_rdata;
  logic        valid_out;
  logic        rd_write_out;
  logic [4:0]  rd_out;
  logic [31:0] wb_data_out;
  logic        misalign_out;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  mem_stage dut (
    .clk           (clk),
    .reset         (reset),
    .valid_in      (valid_in),
    .opcode_in     (opcode_in),
    .funct3_in     (funct3_in),
    .result_in     (result_in),
    .store_data_in (store_data_in),
    .rd_in         (rd_in),
    .stall_out     (stall_out),
    .dmem_req      (dmem_req),
    .dmem_we       (dmem_we),
    .dmem_addr     (dmem_addr),
    .dmem_be       (dmem_be),
    .dmem_wdata    (dmem_wdata),
    .dmem_gnt      (dmem_gnt),
    .dmem_rvalid   (dmem_rvalid),
    .dmem_rdata    (dmem_rdata),
    .valid_out     (valid_out),
    .rd_write_out  (rd_write_out),
    .rd_out        (rd_out),
    .wb_data_out   (wb_data_out),
    .misalign_out  (misalign_out)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_idle();
    valid_in      = 1'b0;
    opcode_in     = 7'b0;
    funct3_in     = 3'b0;
    result_in     = 32'b0;
    store_data_in = 32'b0;
    rd_in         = 5'b0;
    dmem_gnt      = 1'b0;
    dmem_rvalid   = 1'b0;
    dmem_rdata    = 32'b0;
  endtask

  task automatic drive_op(input logic [6:0] opc, input logic [2:0] f3, input logic [31:0] res,
                          input logic [31:0] sd, input logic [4:0] rd);
    valid_in      = 1'b1;
    opcode_in     = opc;
    funct3_in     = f3;
    result_in     = res;
    store_data_in = sd;
    rd_in         = rd;
  endtask

  task automatic test_reset();
    drive_idle();
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
    #1;
    total++;
    if ({valid_out, rd_write_out, stall_out, dmem_req, dmem_we, misalign_out} !== 6'b0) begin
      bad++;
      $display("[TB] FAIL reset_flags: got %b expected 000000",
               {valid_out, rd_write_out, stall_out, dmem_req, dmem_we, misalign_out});
    end
    total++;
    if ({rd_out, wb_data_out, dmem_addr, dmem_be, dmem_wdata} !== 105'b0) begin
      bad++;
      $display("[TB] FAIL reset_buses: rd=%h wb=%h addr=%h be=%h wdata=%h expected all zero",
               rd_out, wb_data_out, dmem_addr, dmem_be, dmem_wdata);
    end
  endtask

  task automatic test_passthrough();
    logic [6:0]  opc [4] = '{7'b0110011, 7'b0010011, 7'b1100011, 7'b0110011};
    logic [31:0] res [4] = '{32'h0000_1234, 32'hFFFF_0001, 32'h0000_0040, 32'h0000_0077};
    logic [4:0]  rd  [4] = '{5'd5, 5'd31, 5'd3, 5'd0};
    logic        wr  [4] = '{1'b1, 1'b1, 1'b0, 1'b0};
    for (int i = 0; i < 4; i++) begin
      drive_op(opc[i], 3'b000, res[i], 32'h0, rd[i]);
      #1;
      total++;
      if (stall_out !== 1'b0) begin
        bad++;
        $display("[TB] FAIL pass_stall[%0d]: got %b expected 0", i, stall_out);
      end
      step();
      drive_idle();
      #1;
      total++;
      if ({valid_out, rd_write_out, dmem_req, misalign_out, rd_out, wb_data_out} !==
          {1'b1, wr[i], 1'b0, 1'b0, rd[i], res[i]}) begin
        bad++;
        $display("[TB] FAIL pass_out[%0d]: got v=%b w=%b req=%b rd=%0d wb=%h expected v=1 w=%b req=0 rd=%0d wb=%h",
                 i, valid_out, rd_write_out, dmem_req, rd_out, wb_data_out, wr[i], rd[i], res[i]);
      end
      step();
      total++;
      if (valid_out !== 1'b0) begin
        bad++;
        $display("[TB] FAIL pass_one_cycle[%0d]: got %b expected 0", i, valid_out);
      end
    end
  endtask

  task automatic test_stores();
    logic [2:0]  f3   [3] = '{3'b000, 3'b001, 3'b010};
    logic [31:0] addr [3] = '{32'h0000_1003, 32'h0000_1002, 32'h0000_1004};
    logic [31:0] sd   [3] = '{32'h0000_00A5, 32'h1234_ABCD, 32'hDEAD_BEEF};
    logic [3:0]  be   [3] = '{4'b1000, 4'b1100, 4'b1111};
    logic [31:0] wd   [3] = '{32'hA5A5_A5A5, 32'hABCD_ABCD, 32'hDEAD_BEEF};
    int          dly  [3] = '{2, 0, 1};
    for (int i = 0; i < 3; i++) begin
      drive_op(7'b0100011, f3[i], addr[i], sd[i], 5'd9);
      #1;
      total++;
      if (stall_out !== 1'b1) begin
        bad++;
        $display("[TB] FAIL st_accept_stall[%0d]: got %b expected 1", i, stall_out);
      end
      step();
      drive_idle();
      #1;
      for (int w = 0; w <= dly[i]; w++) begin
        total++;
        if ({dmem_req, dmem_we, stall_out, valid_out, dmem_addr, dmem_be, dmem_wdata} !==
            {4'b1110, addr[i] & 32'hFFFF_FFFC, be[i], wd[i]}) begin
          bad++;
          $display("[TB] FAIL st_bus[%0d.%0d]: got req=%b we=%b st=%b v=%b addr=%h be=%b wd=%h expected 1 1 1 0 %h %b %h",
                   i, w, dmem_req, dmem_we, stall_out, valid_out, dmem_addr, dmem_be, dmem_wdata,
                   addr[i] & 32'hFFFF_FFFC, be[i], wd[i]);
        end
        if (w < dly[i]) step();
      end
      dmem_gnt = 1'b1;
      #1;
      total++;
      if ({valid_out, rd_write_out, stall_out} !== 3'b100) begin
        bad++;
        $display("[TB] FAIL st_complete[%0d]: got v=%b w=%b st=%b expected 1 0 0",
                 i, valid_out, rd_write_out, stall_out);
      end
      step();
      dmem_gnt = 1'b0;
      #1;
      total++;
      if ({dmem_req, valid_out, stall_out} !== 3'b000) begin
        bad++;
        $display("[TB] FAIL st_after[%0d]: got req=%b v=%b st=%b expected 000",
                 i, dmem_req, valid_out, stall_out);
      end
    end
  endtask

  task automatic run_load(input int tag, input logic [2:0] f3, input logic [31:0] addr,
                          input logic [4:0] rd, input logic [31:0] rdata,
                          input logic [31:0] exp, input logic exp_wr);
    drive_op(7'b0000011, f3, addr, 32'h0, rd);
    step();
    drive_idle();
    #1;
    total++;
    if ({dmem_req, dmem_we, stall_out, valid_out, misalign_out, dmem_addr} !==
        {5'b10100, addr & 32'hFFFF_FFFC}) begin
      bad++;
      $display("[TB] FAIL ld_req[%0d]: got req=%b we=%b st=%b v=%b mis=%b addr=%h expected 1 0 1 0 0 %h",
               tag, dmem_req, dmem_we, stall_out, valid_out, misalign_out, dmem_addr,
               addr & 32'hFFFF_FFFC);
    end
    dmem_gnt = 1'b1;
    #1;
    total++;
    if ({stall_out, valid_out} !== 2'b10) begin
      bad++;
      $display("[TB] FAIL ld_gnt[%0d]: got st=%b v=%b expected 1 0", tag, stall_out, valid_out);
    end
    step();
    dmem_gnt = 1'b0;
    #1;
    total++;
    if ({dmem_req, stall_out, valid_out} !== 3'b010) begin
      bad++;
      $display("[TB] FAIL ld_wait[%0d]: got req=%b st=%b v=%b expected 0 1 0",
               tag, dmem_req, stall_out, valid_out);
    end
    step();
    dmem_rvalid = 1'b1;
    dmem_rdata  = rdata;
    #1;
    total++;
    if ({valid_out, rd_write_out, stall_out, rd_out, wb_data_out} !== {1'b1, exp_wr, 1'b0, rd, exp}) begin
      bad++;
      $display("[TB] FAIL ld_data[%0d]: got v=%b w=%b st=%b rd=%0d wb=%h expected v=1 w=%b st=0 rd=%0d wb=%h",
               tag, valid_out, rd_write_out, stall_out, rd_out, wb_data_out, exp_wr, rd, exp);
    end
    step();
    drive_idle();
    #1;
    total++;
    if ({valid_out, stall_out, dmem_req} !== 3'b000) begin
      bad++;
      $display("[TB] FAIL ld_after[%0d]: got v=%b st=%b req=%b expected 000",
               tag, valid_out, stall_out, dmem_req);
    end
  endtask

  task automatic test_loads();
    run_load(0, 3'b000, 32'h0000_2002, 5'd10, 32'h0080_0000, 32'hFFFF_FF80, 1'b1);
    run_load(1, 3'b100, 32'h0000_2002, 5'd11, 32'h0080_0000, 32'h0000_0080, 1'b1);
    run_load(2, 3'b001, 32'h0000_2002, 5'd12, 32'hBEEF_1234, 32'hFFFF_BEEF, 1'b1);
    run_load(3, 3'b101, 32'h0000_2000, 5'd13, 32'hBEEF_1234, 32'h0000_1234, 1'b1);
    run_load(4, 3'b010, 32'h0000_2004, 5'd0,  32'hCAFE_F00D, 32'hCAFE_F00D, 1'b0);
    run_load(5, 3'b000, 32'h0000_2001, 5'd1,  32'h1234_7F56, 32'h0000_007F, 1'b1);
  endtask

  task automatic test_unsupported();
    drive_op(7'b0000011, 3'b011, 32'h0000_2000, 32'h0, 5'd7);
    #1;
    total++;
    if (stall_out !== 1'b0) begin
      bad++;
      $display("[TB] FAIL unsup_stall: got %b expected 0", stall_out);
    end
    step();
    drive_op(7'b0100011, 3'b100, 32'h0000_1000, 32'h55, 5'd8);
    #1;
    total++;
    if ({valid_out, rd_write_out, dmem_req, stall_out, wb_data_out} !== {4'b1000, 32'h0000_2000}) begin
      bad++;
      $display("[TB] FAIL unsup_load: got v=%b w=%b req=%b st=%b wb=%h expected 1 0 0 0 00002000",
               valid_out, rd_write_out, dmem_req, stall_out, wb_data_out);
    end
    step();
    drive_idle();
    #1;
    total++;
    if ({valid_out, rd_write_out, dmem_req} !== 3'b100) begin
      bad++;
      $display("[TB] FAIL unsup_store: got v=%b w=%b req=%b expected 1 0 0",
               valid_out, rd_write_out, dmem_req);
    end
    step();
  endtask

  task automatic test_reset_midaccess();
    drive_op(7'b0000011, 3'b010, 32'h0000_2000, 32'h0, 5'd2);
    step();
    drive_idle();
    reset = 1'b1;
    #1;
    total++;
    if (dmem_req !== 1'b1) begin
      bad++;
      $display("[TB] FAIL rst_req_before: got %b expected 1", dmem_req);
    end
    step();
    reset = 1'b0;
    dmem_gnt = 1'b1;
    #1;
    total++;
    if ({dmem_req, stall_out, valid_out} !== 3'b000) begin
      bad++;
      $display("[TB] FAIL rst_req_drop: got req=%b st=%b v=%b expected 000", dmem_req, stall_out, valid_out);
    end
    step();
    dmem_gnt = 1'b0;
    drive_op(7'b0000011, 3'b010, 32'h0000_2004, 32'h0, 5'd3);
    step();
    drive_idle();
    dmem_gnt = 1'b1;
    step();
    dmem_gnt = 1'b0;
    reset = 1'b1;
    step();
    reset = 1'b0;
    #1;
    total++;
    if ({valid_out, rd_write_out, stall_out, dmem_req, misalign_out, rd_out, wb_data_out} !== 42'b0) begin
      bad++;
      $display("[TB] FAIL rst_wait_outputs: got v=%b w=%b st=%b req=%b rd=%0d wb=%h expected all zero",
               valid_out, rd_write_out, stall_out, dmem_req, rd_out, wb_data_out);
    end
    step();
    dmem_rvalid = 1'b1;
    dmem_rdata  = 32'hFFFF_FFFF;
    #1;
    total++;
    if ({valid_out, rd_write_out, stall_out, wb_data_out} !== 35'b0) begin
      bad++;
      $display("[TB] FAIL rst_rvalid_ignored: got v=%b w=%b st=%b wb=%h expected 0 0 0 0",
               valid_out, rd_write_out, stall_out, wb_data_out);
    end
    step();
    drive_idle();
    #1;
    total++;
    if ({valid_out, dmem_req} !== 2'b00) begin
      bad++;
      $display("[TB] FAIL rst_quiet: got v=%b req=%b expected 00", valid_out, dmem_req);
    end
  endtask

  task automatic test_back_to_back();
    drive_op(7'b0100011, 3'b010, 32'h0000_1008, 32'h0BAD_F00D, 5'd0);
    step();
    drive_idle();
    dmem_gnt = 1'b1;
    step();
    drive_op(7'b0000011, 3'b100, 32'h0000_2003, 32'h0, 5'd6);
    #1;
    total++;
    if ({stall_out, valid_out} !== 2'b10) begin
      bad++;
      $display("[TB] FAIL b2b_accept: got st=%b v=%b expected 1 0", stall_out, valid_out);
    end
    step();
    drive_idle();
    #1;
    total++;
    if ({dmem_req, dmem_we, dmem_addr} !== {2'b10, 32'h0000_2000}) begin
      bad++;
      $display("[TB] FAIL b2b_req: got req=%b we=%b addr=%h expected 1 0 00002000", dmem_req, dmem_we, dmem_addr);
    end
    dmem_gnt = 1'b1;
    step();
    dmem_gnt = 1'b0;
    step();
    dmem_rvalid = 1'b1;
    dmem_rdata  = 32'hAB00_0000;
    #1;
    total++;
    if ({valid_out, rd_write_out, wb_data_out} !== {2'b11, 32'h0000_00AB}) begin
      bad++;
      $display("[TB] FAIL b2b_load: got v=%b w=%b wb=%h expected 1 1 000000ab", valid_out, rd_write_out, wb_data_out);
    end
    step();
    drive_op(7'b0110011, 3'b000, 32'h0000_0099, 32'h0, 5'd4);
    step();
    drive_idle();
    #1;
    total++;
    if ({valid_out, rd_write_out, rd_out, wb_data_out} !== {2'b11, 5'd4, 32'h0000_0099}) begin
      bad++;
      $display("[TB] FAIL b2b_alu: got v=%b w=%b rd=%0d wb=%h expected 1 1 4 00000099",
               valid_out, rd_write_out, rd_out, wb_data_out);
    end
    step();
  endtask

`ifdef MEM_STAGE_MISALIGN_TRAP_EN
  task automatic test_misalign();
    logic [2:0]  f3   [2] = '{3'b010, 3'b001};
    logic [6:0]  opc  [2] = '{7'b0000011, 7'b0100011};
    logic [31:0] addr [2] = '{32'h0000_3002, 32'h0000_1001};
    for (int i = 0; i < 2; i++) begin
      drive_op(opc[i], f3[i], addr[i], 32'h1111_2222, 5'd4);
      #1;
      total++;
      if (stall_out !== 1'b0) begin
        bad++;
        $display("[TB] FAIL mis_stall[%0d]: got %b expected 0", i, stall_out);
      end
      step();
      drive_idle();
      #1;
      total++;
      if ({dmem_req, valid_out, rd_write_out, misalign_out, wb_data_out} !== {4'b0101, addr[i]}) begin
        bad++;
        $display("[TB] FAIL mis_trap[%0d]: got req=%b v=%b w=%b mis=%b wb=%h expected 0 1 0 1 %h",
                 i, dmem_req, valid_out, rd_write_out, misalign_out, wb_data_out, addr[i]);
      end
      step();
      total++;
      if ({misalign_out, valid_out, dmem_req} !== 3'b000) begin
        bad++;
        $display("[TB] FAIL mis_one_cycle[%0d]: got mis=%b v=%b req=%b expected 000",
                 i, misalign_out, valid_out, dmem_req);
      end
    end
  endtask
`else
  task automatic test_misalign();
    run_load(6, 3'b010, 32'h0000_3002, 5'd4, 32'h1122_3344, 32'h1122_3344, 1'b1);
    run_load(7, 3'b001, 32'h0000_3003, 5'd5, 32'h8765_4321, 32'hFFFF_8765, 1'b1);
    total++;
    if (misalign_out !== 1'b0) begin
      bad++;
      $display("[TB] FAIL mis_off: got %b expected 0", misalign_out);
    end
  endtask
`endif

  initial begin
    drive_idle();
    reset = 1'b1;
    test_reset();
    test_passthrough();
    test_stores();
    test_loads();
    test_unsupported();
    test_reset_midaccess();
    test_back_to_back();
    test_misalign();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- Pipeline stage directly downstream of the execute stage.
- Consumes the ALU result (address or value), rs2 store data, opcode/funct3 and destination register.
- Performs RV32I loads and stores over a single-outstanding data-memory request/grant/response bus, then presents writeback data.
- Non-memory instructions pass through with one-cycle latency. Memory ops stall the upstream pipeline until the access completes.

Parameters:
- ADDR_W, 32, data-memory byte-address width.
- XLEN, 32, datapath width; only 32 is supported.

Ports:
- clk  in  1  single clock; all state updates on its rising edge.
- reset  in  1  synchronous, active-high reset.
- valid_in  in  1  execute output holds a valid instruction.
- opcode_in  in  7  instruction opcode.
- funct3_in  in  3  width/sign selector.
- result_in  in  XLEN  ALU result; the byte address for loads and stores.
- store_data_in  in  XLEN  rs2 value for stores.
- rd_in  in  5  destination register.
- stall_out  out  1  upstream must hold its outputs.
- dmem_req  out  1  bus request.
- dmem_we  out  1  1 = store.
- dmem_addr  out  ADDR_W  word-aligned address {addr[ADDR_W-1:2],2'b00}.
- dmem_be  out  4  byte enables.
- dmem_wdata  out  XLEN  lane-aligned store data.
- dmem_gnt  in  1  request accepted this cycle.
- dmem_rvalid  in  1  load data valid.
- dmem_rdata  in  XLEN  load word.
- valid_out  out  1  writeback slot valid.
- rd_write_out  out  1  writeback enable.
- rd_out  out  5  destination register.
- wb_data_out  out  XLEN  writeback value.
- misalign_out  out  1  misaligned access flag; tied 0 unless the optional feature is compiled in.

Behaviour:
- Reset:
  - state = IDLE.
  - All outputs 0: valid_out, rd_write_out, rd_out, wb_data_out, dmem_*, stall_out, misalign_out.
  - Reset mid-access drops dmem_req on the next cycle. Any later dmem_rvalid/dmem_gnt received in IDLE is ignored.
- States and transitions:
  - IDLE -> REQ on accepting a load/store.
  - REQ -> IDLE when dmem_gnt arrives for a store.
  - REQ -> WAIT when dmem_gnt arrives for a load.
  - WAIT -> IDLE when dmem_rvalid arrives.
- Bus timing:
  - dmem_req, dmem_we, dmem_addr, dmem_be and dmem_wdata are registered and held stable until dmem_gnt.
  - dmem_rvalid never arrives in the same cycle as dmem_gnt.
- Accepting a non-memory op (IDLE, valid_in=1):
  - Next cycle: valid_out=1, wb_data_out=result_in, rd_out=rd_in.
  - rd_write_out=1 unless opcode is 0100011 (store) or 1100011 (branch), or rd_in==0.
  - Latency is 1 cycle.
- Accepting a load/store (opcode 0000011 / 0100011):
  - Registers address, funct3, rd and store data.
  - Enters REQ and asserts dmem_req the next cycle.
  - valid_out=0 meanwhile.
- stall_out:
  - Combinational.
  - High in REQ and WAIT.
  - High in IDLE while valid_in carries a memory op being accepted in that cycle.
  - Low in the completion cycle.
- Store completion:
  - On dmem_gnt: valid_out=1 for 1 cycle, rd_write_out=0.
  - Store latency = 1 + grant wait.
- Load completion:
  - On dmem_rvalid: valid_out=1 and rd_write_out=(rd!=0) for 1 cycle.
  - wb_data_out = aligned and extended data.
- Store lane shaping (a = addr[1:0]):
  - SB: be = 4'b0001<<a; wdata = byte replicated ×4.
  - SH: be = 4'b0011<<{a[1],1'b0}; wdata = halfword replicated ×2.
  - SW: be = 4'b1111.
- Load extraction:
  - LB/LBU: byte a, sign- or zero-extended.
  - LH/LHU: halfword a[1], sign- or zero-extended.
  - LW: full word.
- Unsupported funct3 (load 011/110/111, store ≥011): no bus access; handled as a non-memory op with rd_write_out=0.
- Misaligned accesses (macro off): silently truncated (low address bits ignored for the halfword/word select).
- Back-to-back: a new op is accepted in the completion cycle's following cycle (IDLE); no overlap of accesses.

Optional Feature:
- Macro: MEM_STAGE_MISALIGN_TRAP_EN.
- Defined:
  - LH/LHU/SH with addr[0]=1, or LW/SW with addr[1:0]≠0, issue no bus request.
  - Next cycle: valid_out=1, misalign_out=1, rd_write_out=0, wb_data_out=faulting address.
  - misalign_out lasts exactly 1 cycle.
- Undefined: misalign_out is constant 0; misaligned accesses are truncated as above.

Decomposition:
- Package rv_pkg:
  - Opcode constants (LOAD, STORE, BRANCH).
  - funct3 constants (LB, LH, LW, LBU, LHU, SB, SH, SW).
  - mem_state_t enum {IDLE, REQ, WAIT}.
- One combinational sub-module, mem_load_align: inputs rdata, addr[1:0], funct3; output extended word.

Test Plan:
- ADD result 0x1234, rd=5, valid 1 cycle -> next cycle valid_out=1, rd_write_out=1, wb_data_out=0x00001234, no dmem_req.
- SB addr 0x1003, data 0x000000A5, gnt after 2 cycles -> dmem_addr=0x1000, be=4'b1000, wdata=0xA5A5A5A5, stall_out high throughout, valid_out with rd_write_out=0 on the gnt cycle.
- LB addr 0x2002, rdata 0x00800000 -> wb_data_out=0xFFFFFF80; LBU at the same address -> 0x00000080.
- LH addr 0x2002, rdata 0xBEEF1234 -> wb_data_out=0xFFFFBEEF; load with rd=0 -> rd_write_out=0.
- reset asserted in WAIT, then rvalid 2 cycles later -> outputs 0, dmem_req low after 1 cycle, rvalid ignored, valid_out stays 0.
- With macro: LW addr 0x3002 -> no dmem_req, misalign_out=1, wb_data_out=0x3002 for one cycle.
